alu_seq_unit: RTL and testbench

//   Arithmetic/logic stage directly downstream of the register file.
//   - Consumes the two register-file read ports (OutA -> A, OutB -> B).
//   - Executes one operation per Start: single-cycle ops, plus an iterative 32-cycle shift-add multiply.
//   - Holds the result in ALUOut and keeps a 4-bit flag register {Z,C,N,O}.
//   - ALUOut is written back to the register file through its I input by the control unit.

---
 rtl/alu_seq_unit_pkg.sv | 37 +++
 rtl/alu_seq_unit_mul.sv | 79 +++++++
 rtl/alu_seq_unit.sv | 167 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_unit_pkg.sv
// Shared definitions for the ALU stage: datapath width, opcodes, FSM states
// and the {Z,C,N,O} flag layout.
package alu_seq_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    // Opcode map; 4'b1100..4'b1111 are reserved and have no enumerator.
    typedef enum logic [OP_W-1:0] {
        OP_PASS_A = 4'b0000,
        OP_PASS_B = 4'b0001,
        OP_NOT_A  = 4'b0010,
        OP_ADD    = 4'b0011,
        OP_SUB    = 4'b0100,
        OP_AND    = 4'b0101,
        OP_OR     = 4'b0110,
        OP_XOR    = 4'b0111,
        OP_LSL    = 4'b1000,
        OP_LSR    = 4'b1001,
        OP_ASR    = 4'b1010,
        OP_MUL    = 4'b1011
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    // Packed so that z lands on bit 3 and o on bit 0 of the flag bus.
    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic o;
    } flags_t;

endpackage

// File: rtl/alu_seq_unit_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per clock.
//   clk, rst_n  : clock, async active-low reset (also aborts a multiply)
//   start_i     : latch a_i/b_i and begin; ignored while a multiply runs
//   a_i, b_i    : WIDTH-bit unsigned operands
//   done_o      : one-cycle pulse once p_o holds the complete product
//   p_o         : 2*WIDTH-bit product, held until the next start
module alu_seq_unit_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   p_o
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [PW-1:0]     prod_q, prod_d;

    // The first partial product is taken on the start edge itself, so the
    // last of the WIDTH iterations lands WIDTH-1 edges after start.
    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (start_i && !busy_q) begin
            prod_d   = b_i[0] ? PW'(a_i) : '0;
            mcand_d  = PW'(a_i) << 1;
            mplier_d = b_i >> 1;
            cnt_d    = CNT_W'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign done_o = done_q;
    assign p_o    = prod_q;

endmodule

// File: rtl/alu_seq_unit.sv
// ALU stage behind the register file: single-cycle ops plus an iterative
// multiply, with a registered result and {Z,C,N,O} flag register.
//   clk, rst_n  : clock, async active-low reset (aborts a multiply)
//   a_i, b_i    : operands from register-file OutA / OutB
//   fun_sel_i   : opcode, sampled with start_i
//   wf_i        : flag write enable, sampled with start_i
//   start_i     : begin an operation; ignored while busy_o
//   busy_o      : multiply in progress
//   done_o      : one-cycle pulse, alu_out_o/flags_o are new this cycle
//   alu_out_o   : registered result
//   flags_o     : registered {Z,C,N,O}
module alu_seq_unit
    import alu_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [OP_W-1:0]   fun_sel_i,
    input  logic              wf_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  alu_out_o,
    output logic [3:0]        flags_o
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    alu_out_q, alu_out_d;
    flags_t              flags_q, flags_d;
    logic                done_q, done_d;
    logic                wf_q, wf_d;
    logic                mul_start_c;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_p;

    logic [WIDTH:0]      add_ext_c;
    logic [WIDTH:0]      sub_ext_c;
    logic [WIDTH-1:0]    op_res_c;
    logic                op_c_c;
    logic                op_o_c;
    logic                op_valid_c;

    alu_seq_unit_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start_c),
        .a_i     (a_i),
        .b_i     (b_i),
        .done_o  (mul_done),
        .p_o     (mul_p)
    );

    // Subtraction as A + ~B + 1 so the carry-out reads as "no borrow".
    assign add_ext_c = {1'b0, a_i} + {1'b0, b_i};
    assign sub_ext_c = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH + 1)'(1);

    // Single-cycle datapath; C/O default to their held values.
    always_comb begin
        op_res_c   = '0;
        op_c_c     = flags_q.c;
        op_o_c     = flags_q.o;
        op_valid_c = 1'b1;
        case (fun_sel_i)
            OP_PASS_A: op_res_c = a_i;
            OP_PASS_B: op_res_c = b_i;
            OP_NOT_A:  op_res_c = ~a_i;
            OP_ADD: begin
                op_res_c = add_ext_c[WIDTH-1:0];
                op_c_c   = add_ext_c[WIDTH];
                op_o_c   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                           (add_ext_c[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                op_res_c = sub_ext_c[WIDTH-1:0];
                op_c_c   = sub_ext_c[WIDTH];
                op_o_c   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                           (sub_ext_c[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:    op_res_c = a_i & b_i;
            OP_OR:     op_res_c = a_i | b_i;
            OP_XOR:    op_res_c = a_i ^ b_i;
            OP_LSL: begin
                op_res_c = {a_i[WIDTH-2:0], 1'b0};
                op_c_c   = a_i[WIDTH-1];
            end
            OP_LSR: begin
                op_res_c = {1'b0, a_i[WIDTH-1:1]};
                op_c_c   = a_i[0];
            end
            OP_ASR: begin
                op_res_c = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
                op_c_c   = a_i[0];
            end
            default:   op_valid_c = 1'b0;
        endcase
    end

    // Sequencing: IDLE issues ops, MUL waits for the multiplier to finish.
    always_comb begin
        state_d     = state_q;
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        wf_d        = wf_q;
        mul_start_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (fun_sel_i == OP_MUL) begin
                        mul_start_c = 1'b1;
                        wf_d        = wf_i;
                        state_d     = S_MUL;
                    end else begin
                        alu_out_d = op_res_c;
                        done_d    = 1'b1;
                        if (wf_i && op_valid_c) begin
                            flags_d.z = (op_res_c == '0);
                            flags_d.c = op_c_c;
                            flags_d.n = op_res_c[WIDTH-1];
                            flags_d.o = op_o_c;
                        end
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    alu_out_d = mul_p[WIDTH-1:0];
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                    if (wf_q) begin
                        flags_d.z = (mul_p[WIDTH-1:0] == '0);
                        flags_d.n = mul_p[WIDTH-1];
                        flags_d.o = |mul_p[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            alu_out_q <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            wf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            wf_q      <= wf_d;
        end
    end

    assign busy_o    = (state_q == S_MUL);
    assign done_o    = done_q;
    assign alu_out_o = alu_out_q;
    assign flags_o   = flags_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed vector table, randomized
// ops against an arithmetic reference model, and multi-cycle corner cases.
module tb_alu_seq_unit;

    localparam logic [3:0] T_PASS_A = 4'd0;
    localparam logic [3:0] T_PASS_B = 4'd1;
    localparam logic [3:0] T_NOT    = 4'd2;
    localparam logic [3:0] T_ADD    = 4'd3;
    localparam logic [3:0] T_SUB    = 4'd4;
    localparam logic [3:0] T_AND    = 4'd5;
    localparam logic [3:0] T_OR     = 4'd6;
    localparam logic [3:0] T_XOR    = 4'd7;
    localparam logic [3:0] T_LSL    = 4'd8;
    localparam logic [3:0] T_LSR    = 4'd9;
    localparam logic [3:0] T_ASR    = 4'd10;
    localparam logic [3:0] T_MUL    = 4'd11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_in, b_in;
    logic [3:0]  fun_sel;
    logic        wf_in, start;
    logic        busy, done;
    logic [31:0] alu_out;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    alu_seq_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_i       (a_in),
        .b_i       (b_in),
        .fun_sel_i (fun_sel),
        .wf_i      (wf_in),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .alu_out_o (alu_out),
        .flags_o   (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        wf;
        logic [31:0] er;
        logic [3:0]  ef;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  fl;
    } mres_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic with signed range tests for overflow.
    function automatic mres_t ref_model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic wf,
                                        input logic [3:0] fl_in);
        mres_t       r;
        logic [63:0] wide;
        longint      s;
        logic        c, o, upd;
        c   = fl_in[2];
        o   = fl_in[0];
        upd = 1'b1;
        r.res = 32'h0;
        case (op)
            T_PASS_A: r.res = a;
            T_PASS_B: r.res = b;
            T_NOT:    r.res = ~a;
            T_ADD: begin
                wide  = 64'(a) + 64'(b);
                r.res = wide[31:0];
                c     = wide[32];
                s     = longint'($signed(a)) + longint'($signed(b));
                o     = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            T_SUB: begin
                r.res = a - b;
                c     = (a >= b);
                s     = longint'($signed(a)) - longint'($signed(b));
                o     = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            T_AND:    r.res = a & b;
            T_OR:     r.res = a | b;
            T_XOR:    r.res = a ^ b;
            T_LSL: begin r.res = a << 1; c = a[31]; end
            T_LSR: begin r.res = a >> 1; c = a[0];  end
            T_ASR: begin r.res = 32'($signed(a) >>> 1); c = a[0]; end
            T_MUL: begin
                wide  = 64'(a) * 64'(b);
                r.res = wide[31:0];
                o     = (wide[63:32] != 32'h0);
            end
            default: upd = 1'b0;
        endcase
        if (wf && upd) r.fl = {(r.res == 32'h0), c, r.res[31], o};
        else           r.fl = fl_in;
        return r;
    endfunction

    // Issue one operation and compare once Done is expected.
    task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wf, input logic [31:0] er, input logic [3:0] ef,
                        input string name);
        int edges;
        @(negedge clk);
        fun_sel = op; a_in = a; b_in = b; wf_in = wf; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (op == T_MUL) begin
            check({name, " busy"}, 64'(busy), 64'd1);
            edges = 0;
            while (!done && edges < 100) begin
                @(posedge clk);
                #1;
                edges++;
            end
            check({name, " mul_latency"}, 64'(edges), 64'd32);
            check({name, " busy_clear"}, 64'(busy), 64'd0);
        end else begin
            check({name, " done"}, 64'(done), 64'd1);
        end
        check({name, " result"}, 64'(alu_out), 64'(er));
        check({name, " flags"}, 64'(flags), 64'(ef));
    endtask

    vec_t        tbl[15];
    logic [3:0]  exp_fl;
    logic [31:0] edge_vals[5];

    initial begin
        int    dcnt, done_edge, busy_bad;
        mres_t r;
        logic [3:0]  op;
        logic [31:0] ra, rb;
        logic        rwf;

        edge_vals[0] = 32'h0;        edge_vals[1] = 32'hFFFFFFFF;
        edge_vals[2] = 32'h80000000; edge_vals[3] = 32'h7FFFFFFF;
        edge_vals[4] = 32'h1;

        tbl[0]  = '{T_ADD,    32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 4'b1100};
        tbl[1]  = '{T_SUB,    32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b0101};
        tbl[2]  = '{T_LSL,    32'h80000001, 32'h00000000, 1'b1, 32'h00000002, 4'b0101};
        tbl[3]  = '{T_XOR,    32'h0000FFFF, 32'hFFFF0000, 1'b0, 32'hFFFFFFFF, 4'b0101};
        tbl[4]  = '{T_AND,    32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 32'h00000000, 4'b1101};
        tbl[5]  = '{T_ASR,    32'h80000000, 32'h00000000, 1'b1, 32'hC0000000, 4'b0011};
        tbl[6]  = '{4'b1101,  32'h00000005, 32'h00000006, 1'b1, 32'h00000000, 4'b0011};
        tbl[7]  = '{T_NOT,    32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b0011};
        tbl[8]  = '{T_MUL,    32'h00010000, 32'h00010000, 1'b1, 32'h00000000, 4'b1001};
        tbl[9]  = '{T_PASS_B, 32'h00000001, 32'h80000000, 1'b1, 32'h80000000, 4'b0011};
        tbl[10] = '{T_SUB,    32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 4'b0010};
        tbl[11] = '{T_ADD,    32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 4'b0011};
        tbl[12] = '{T_OR,     32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b1001};
        tbl[13] = '{T_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 4'b0001};
        tbl[14] = '{T_PASS_A, 32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 4'b0001};

        rst_n = 1'b0; a_in = '0; b_in = '0; fun_sel = '0; wf_in = 1'b0; start = 1'b0;
        #12;
        check("reset alu_out", 64'(alu_out), 64'd0);
        check("reset flags",   64'(flags),   64'd0);
        check("reset busy",    64'(busy),    64'd0);
        check("reset done",    64'(done),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply with a Start pulsed mid-flight: it must be ignored.
        @(negedge clk);
        fun_sel = T_MUL; a_in = 32'h00010000; b_in = 32'h00010000; wf_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0; done_edge = 0; busy_bad = 0;
        for (int e = 1; e <= 45; e++) begin
            @(negedge clk);
            if (e == 10) begin
                fun_sel = T_ADD; a_in = 32'h1; b_in = 32'h1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin dcnt++; done_edge = e; end
            if (busy !== (e < 32)) busy_bad++;
        end
        check("midstart done_count", 64'(dcnt), 64'd1);
        check("midstart done_edge",  64'(done_edge), 64'd32);
        check("midstart busy_shape", 64'(busy_bad), 64'd0);
        check("midstart result",     64'(alu_out), 64'd0);
        check("midstart flags",      64'(flags), 64'(4'b1001));

        for (int i = 0; i < 15; i++) begin
            exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].wf, tbl[i].er, tbl[i].ef,
                 $sformatf("vec%0d", i));
        end

        exp_fl = tbl[14].ef;
        for (int i = 0; i < 250; i++) begin
            op  = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            rwf = 1'($urandom_range(0, 1));
            r   = ref_model(op, ra, rb, rwf, exp_fl);
            exec(op, ra, rb, rwf, r.res, r.fl, $sformatf("rand%0d op%0d", i, op));
            exp_fl = r.fl;
        end

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        fun_sel = T_MUL; a_in = 32'h3; b_in = 32'h5; wf_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst alu_out", 64'(alu_out), 64'd0);
        check("async_rst flags",   64'(flags),   64'd0);
        check("async_rst busy",    64'(busy),    64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exec(T_ADD, 32'h3, 32'h4, 1'b1, 32'h7, 4'b0000, "post_rst add");
        dcnt = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("post_rst stray_done", 64'(dcnt), 64'd0);

        // Start held high across three single-cycle ops.
        @(negedge clk);
        fun_sel = T_ADD; a_in = 32'd10; b_in = 32'd20; wf_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b add done", 64'(done), 64'd1);
        check("b2b add res",  64'(alu_out), 64'd30);
        fun_sel = T_AND; a_in = 32'hF0; b_in = 32'h3C;
        @(posedge clk);
        #1;
        check("b2b and done", 64'(done), 64'd1);
        check("b2b and res",  64'(alu_out), 64'h30);
        fun_sel = T_OR; a_in = 32'hF0; b_in = 32'h0F;
        @(posedge clk);
        #1;
        check("b2b or done", 64'(done), 64'd1);
        check("b2b or res",  64'(alu_out), 64'hFF);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b done_drop", 64'(done), 64'd0);
        check("b2b hold_res",  64'(alu_out), 64'hFF);
        check("b2b flags",     64'(flags), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
